hazard_ctrl_mdu: RTL and testbench

Parametrised stall/forward controller for the 5-stage pipeline.
- Compares NUM_SRC source operands per instruction against the E/M/W producers using Tnew/Tuse, and generates stall and per-operand forward selects for the D, E and M stages.
- Owns the multiply/divide busy timer, so the MDU reports no busy of its own.
- Adds a saturating stall-cycle performance counter.
- Sits beside the datapath and drives the D-stage stall/freeze and the forward muxes.

---
 rtl/hazard_ctrl_mdu_pkg.sv | 19 +
 rtl/hazard_ctrl_mdu_md_busy_timer.sv | 39 +++
 rtl/hazard_ctrl_mdu.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl_mdu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_mdu_pkg.sv
// Shared encodings for the hazard controller: forward-mux selects, the
// "operand unused" Tuse code, and the producer-match rule.
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_W     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  localparam logic [1:0] FWD_E     = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  // A producer only counts if it really writes a non-zero register.
  function automatic logic prod_match(input logic       regwrite,
                                      input logic [4:0] wr,
                                      input logic [4:0] addr);
    return regwrite && (wr == addr) && (wr != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_md_busy_timer.sv
// Multiply/divide busy timer: loads the op latency on an E-stage start and
// counts down; md_busy is high while the count is non-zero.
module md_busy_timer #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  localparam int CW = $clog2(DIV_LAT + 1);

  logic [CW-1:0] md_cnt_q;
  logic [CW-1:0] md_cnt_d;

  // A start always (re)loads, even while busy, so a stray restart is safe.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start) begin
      md_cnt_d = md_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl_mdu.sv
// Stall/forward controller for the 5-stage pipeline, with the MDU busy timer
// and a saturating stall-cycle counter.
module hazard_ctrl_mdu
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SRC*5-1:0]   src_addr_D,
  input  logic [NUM_SRC*2-1:0]   src_tuse_D,
  input  logic [NUM_SRC*5-1:0]   src_addr_E,
  input  logic [4:0]             rt_M,
  input  logic                   regwrite_E,
  input  logic                   regwrite_M,
  input  logic                   regwrite_W,
  input  logic [4:0]             wr_E,
  input  logic [4:0]             wr_M,
  input  logic [4:0]             wr_W,
  input  logic [1:0]             tnew_E,
  input  logic [1:0]             tnew_M,
  input  logic                   md_start_E,
  input  logic                   md_is_div_E,
  input  logic                   md_rel_D,
  output logic                   stall,
  output logic [NUM_SRC*2-1:0]   fwd_D,
  output logic [NUM_SRC*2-1:0]   fwd_E,
  output logic                   fwd_M,
  output logic                   md_busy,
  output logic [CNT_W-1:0]       stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [NUM_SRC-1:0] data_stall;
  logic               md_stall;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [4:0] addr_d;
    logic [4:0] addr_e;
    logic [1:0] tuse;
    logic       e_hit_d;
    logic       m_hit_d;
    logic       w_hit_d;
    logic       m_hit_e;
    logic       w_hit_e;
    logic [1:0] sel_d;
    logic [1:0] sel_e;

    assign addr_d  = src_addr_D[5*i +: 5];
    assign addr_e  = src_addr_E[5*i +: 5];
    assign tuse    = src_tuse_D[2*i +: 2];

    assign e_hit_d = prod_match(regwrite_E, wr_E, addr_d);
    assign m_hit_d = prod_match(regwrite_M, wr_M, addr_d);
    assign w_hit_d = prod_match(regwrite_W, wr_W, addr_d);
    assign m_hit_e = prod_match(regwrite_M, wr_M, addr_e);
    assign w_hit_e = prod_match(regwrite_W, wr_W, addr_e);

    // Stall when the value is produced later than the operand is needed.
    assign data_stall[i] = (tuse != TUSE_NONE) &&
                           ((e_hit_d && (tnew_E > tuse)) ||
                            (m_hit_d && (tnew_M > tuse)));

    always_comb begin
      sel_d = FWD_RF;
      if (e_hit_d && (tnew_E == 2'd0)) begin
        sel_d = FWD_E;
      end else if (m_hit_d && (tnew_M == 2'd0)) begin
        sel_d = FWD_M;
      end else if (w_hit_d) begin
        sel_d = FWD_W;
      end
    end

    always_comb begin
      sel_e = FWD_RF;
      if (m_hit_e && (tnew_M == 2'd0)) begin
        sel_e = FWD_M;
      end else if (w_hit_e) begin
        sel_e = FWD_W;
      end
    end

    assign fwd_D[2*i +: 2] = sel_d;
    assign fwd_E[2*i +: 2] = sel_e;
  end

  assign fwd_M = prod_match(regwrite_W, wr_W, rt_M);

  md_busy_timer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_timer (
    .clk       (clk),
    .reset     (reset),
    .md_start  (md_start_E),
    .md_is_div (md_is_div_E),
    .md_busy   (md_busy)
  );

  // Counting the start cycle too keeps HI/LO readers in D until the timer drains.
  assign md_stall = md_rel_D && (md_start_E || md_busy);
  assign stall    = (|data_stall) || md_stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mdu.sv
// Directed bench for hazard_ctrl_mdu: forwarding, stalls, MDU timer, counter.
module tb_hazard_ctrl_mdu;

  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS*5-1:0] src_addr_D;
  logic [NS*2-1:0] src_tuse_D;
  logic [NS*5-1:0] src_addr_E;
  logic [4:0]    rt_M;
  logic          regwrite_E, regwrite_M, regwrite_W;
  logic [4:0]    wr_E, wr_M, wr_W;
  logic [1:0]    tnew_E, tnew_M;
  logic          md_start_E, md_is_div_E, md_rel_D;

  logic          stall, stall_s;
  logic [NS*2-1:0] fwd_D, fwd_E, fwd_D_s, fwd_E_s;
  logic          fwd_M, fwd_M_s;
  logic          md_busy, md_busy_s;
  logic [31:0]   stall_cnt;
  logic [3:0]    stall_cnt_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mdu #(.NUM_SRC(NS), .MUL_LAT(5), .DIV_LAT(10), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .src_addr_D(src_addr_D), .src_tuse_D(src_tuse_D),
    .src_addr_E(src_addr_E), .rt_M(rt_M), .regwrite_E(regwrite_E),
    .regwrite_M(regwrite_M), .regwrite_W(regwrite_W), .wr_E(wr_E), .wr_M(wr_M),
    .wr_W(wr_W), .tnew_E(tnew_E), .tnew_M(tnew_M), .md_start_E(md_start_E),
    .md_is_div_E(md_is_div_E), .md_rel_D(md_rel_D), .stall(stall), .fwd_D(fwd_D),
    .fwd_E(fwd_E), .fwd_M(fwd_M), .md_busy(md_busy), .stall_cnt(stall_cnt));

  hazard_ctrl_mdu #(.NUM_SRC(NS), .MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .src_addr_D(src_addr_D), .src_tuse_D(src_tuse_D),
    .src_addr_E(src_addr_E), .rt_M(rt_M), .regwrite_E(regwrite_E),
    .regwrite_M(regwrite_M), .regwrite_W(regwrite_W), .wr_E(wr_E), .wr_M(wr_M),
    .wr_W(wr_W), .tnew_E(tnew_E), .tnew_M(tnew_M), .md_start_E(md_start_E),
    .md_is_div_E(md_is_div_E), .md_rel_D(md_rel_D), .stall(stall_s), .fwd_D(fwd_D_s),
    .fwd_E(fwd_E_s), .fwd_M(fwd_M_s), .md_busy(md_busy_s), .stall_cnt(stall_cnt_s));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    src_addr_D = '0; src_tuse_D = {NS{2'd3}}; src_addr_E = '0; rt_M = '0;
    regwrite_E = 0; regwrite_M = 0; regwrite_W = 0;
    wr_E = '0; wr_M = '0; wr_W = '0; tnew_E = '0; tnew_M = '0;
    md_start_E = 0; md_is_div_E = 0; md_rel_D = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #3;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", md_busy); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_raw_alu();
    clear_inputs();
    regwrite_E = 1; wr_E = 5'd8; tnew_E = 2'd1;
    src_addr_D = {5'd0, 5'd8}; src_tuse_D = {2'd3, 2'd0};
    settle();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_e_stall: got %b expected 1", stall); end
    checks++; if (fwd_D !== 4'b0000) begin errors++; $display("FAIL raw_e_fwd: got %b expected 0000", fwd_D); end
    step();
    regwrite_E = 0; wr_E = '0; tnew_E = '0;
    regwrite_M = 1; wr_M = 5'd8; tnew_M = 2'd0;
    settle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_m_stall: got %b expected 0", stall); end
    checks++; if (fwd_D !== 4'b0010) begin errors++; $display("FAIL raw_m_fwd: got %b expected 0010", fwd_D); end
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL raw_cnt: got %0d expected 1", stall_cnt); end
    // M producer still one cycle away, operand needed now
    tnew_M = 2'd1;
    settle();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_m_late: got %b expected 1", stall); end
    // Operand needed later than the E result arrives: no stall
    clear_inputs();
    regwrite_E = 1; wr_E = 5'd9; tnew_E = 2'd1;
    src_addr_D = {5'd9, 5'd0}; src_tuse_D = {2'd1, 2'd3};
    settle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL tuse_eq: got %b expected 0", stall); end
    tnew_E = 2'd2; src_tuse_D = {2'd3, 2'd3};
    settle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL tuse_none: got %b expected 0", stall); end
    step();
  endtask

  task automatic test_link();
    clear_inputs();
    regwrite_E = 1; wr_E = 5'd31; tnew_E = 2'd0;
    src_addr_D = {5'd31, 5'd4}; src_tuse_D = {2'd1, 2'd0};
    settle();
    checks++; if (fwd_D !== 4'b1100) begin errors++; $display("FAIL link_fwd: got %b expected 1100", fwd_D); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL link_stall: got %b expected 0", stall); end
    step();
  endtask

  task automatic test_reg0();
    clear_inputs();
    regwrite_E = 1; regwrite_M = 1; regwrite_W = 1;
    tnew_E = 2'd2; tnew_M = 2'd1;
    src_tuse_D = {2'd0, 2'd0};
    settle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b expected 0", stall); end
    checks++; if (fwd_D !== 4'b0000) begin errors++; $display("FAIL r0_fwd_d: got %b expected 0000", fwd_D); end
    checks++; if (fwd_E !== 4'b0000) begin errors++; $display("FAIL r0_fwd_e: got %b expected 0000", fwd_E); end
    checks++; if (fwd_M !== 1'b0) begin errors++; $display("FAIL r0_fwd_m: got %b expected 0", fwd_M); end
    step();
  endtask

  task automatic test_priority();
    clear_inputs();
    regwrite_M = 1; regwrite_W = 1; wr_M = 5'd5; wr_W = 5'd5; tnew_M = 2'd0;
    src_addr_E = {5'd0, 5'd5}; rt_M = 5'd5;
    settle();
    checks++; if (fwd_E !== 4'b0010) begin errors++; $display("FAIL prio_m: got %b expected 0010", fwd_E); end
    checks++; if (fwd_M !== 1'b1) begin errors++; $display("FAIL fwd_m_hit: got %b expected 1", fwd_M); end
    tnew_M = 2'd1;
    settle();
    checks++; if (fwd_E !== 4'b0001) begin errors++; $display("FAIL prio_w: got %b expected 0001", fwd_E); end
    rt_M = 5'd6;
    settle();
    checks++; if (fwd_M !== 1'b0) begin errors++; $display("FAIL fwd_m_miss: got %b expected 0", fwd_M); end
    // D side: E beats M beats W
    regwrite_E = 1; wr_E = 5'd5; tnew_E = 2'd0; tnew_M = 2'd0;
    src_addr_D = {5'd5, 5'd5}; src_tuse_D = {2'd1, 2'd1};
    settle();
    checks++; if (fwd_D !== 4'b1111) begin errors++; $display("FAIL prio_d_e: got %b expected 1111", fwd_D); end
    regwrite_E = 0;
    settle();
    checks++; if (fwd_D !== 4'b1010) begin errors++; $display("FAIL prio_d_m: got %b expected 1010", fwd_D); end
    regwrite_M = 0;
    settle();
    checks++; if (fwd_D !== 4'b0101) begin errors++; $display("FAIL prio_d_w: got %b expected 0101", fwd_D); end
    step();
  endtask

  task automatic test_divide();
    clear_inputs();
    pulse_reset();
    md_start_E = 1; md_is_div_E = 1; md_rel_D = 1;
    settle();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL div_start_stall: got %b expected 1", stall); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL div_start_busy: got %b expected 0", md_busy); end
    step();
    md_start_E = 0; md_is_div_E = 0;
    for (int k = 1; k <= 10; k++) begin
      settle();
      checks++; if (md_busy !== 1'b1 || stall !== 1'b1) begin
        errors++; $display("FAIL div_busy_c%0d: got busy=%b stall=%b expected 1/1", k, md_busy, stall);
      end
      step();
    end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL div_done_busy: got %b expected 0", md_busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL div_done_stall: got %b expected 0", stall); end
    checks++; if (stall_cnt !== 32'd11) begin errors++; $display("FAIL div_cnt: got %0d expected 11", stall_cnt); end
    md_rel_D = 0;
    // Multiply: five busy cycles
    md_start_E = 1;
    step();
    md_start_E = 0;
    for (int k = 1; k <= 5; k++) begin
      checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL mul_busy_c%0d: got %b expected 1", k, md_busy); end
      step();
    end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mul_done: got %b expected 0", md_busy); end
    checks++; if (stall_cnt !== 32'd11) begin errors++; $display("FAIL mul_cnt: got %0d expected 11", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    md_start_E = 1; md_is_div_E = 1; md_rel_D = 1;
    step();
    md_start_E = 0; md_is_div_E = 0;
    step();
    step();
    #1;
    reset = 1'b0;
    md_rel_D = 0;
    regwrite_E = 1; wr_E = 5'd3; tnew_E = 2'd2;
    src_addr_D = {5'd0, 5'd3}; src_tuse_D = {2'd3, 2'd1};
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", md_busy); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rmid_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmid_comb: got %b expected 1", stall); end
    clear_inputs();
    #1;
    reset = 1'b1;
    step();
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rmid_after: got %b expected 0", md_busy); end
  endtask

  task automatic test_saturation();
    clear_inputs();
    pulse_reset();
    regwrite_E = 1; wr_E = 5'd12; tnew_E = 2'd1;
    src_addr_D = {5'd0, 5'd12}; src_tuse_D = {2'd3, 2'd0};
    for (int k = 0; k < 14; k++) step();
    checks++; if (stall_cnt_s !== 4'd14) begin errors++; $display("FAIL sat_14: got %0d expected 14", stall_cnt_s); end
    for (int k = 14; k < 20; k++) step();
    checks++; if (stall_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", stall_cnt_s); end
    checks++; if (stall_cnt !== 32'd20) begin errors++; $display("FAIL sat_wide: got %0d expected 20", stall_cnt); end
    clear_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_raw_alu();
    test_link();
    test_reg0();
    test_priority();
    test_divide();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
